// File: rtl/instruction_fetch_decode_if.sv
// Execution-side bundle of the fetch/decode unit:
// issue outputs plus completion and write-back inputs.
interface instruction_fetch_decode_if #(
  parameter int OP_W   = 16,
  parameter int ADDR_W = 16,
  parameter int ROM_W  = 16,
  parameter int ROW_W  = 96
);
  logic              iExeBusy;
  logic              iALUOutputReady;
  logic              iBranchTaken;
  logic [ROM_W-1:0]  iJumpIp;
  logic              iRAMWriteEnable;
  logic [ADDR_W-1:0] iRAMWriteAddress;
  logic [ROW_W-1:0]  iRAMWriteData;
  logic              oDecodeDone;
  logic [OP_W-1:0]   oOperation;
  logic [ROW_W-1:0]  oSource0;
  logic [ROW_W-1:0]  oSource1;
  logic [ADDR_W-1:0] oDestination;
  logic              oCodeDone;

  modport master (
    input  iExeBusy, iALUOutputReady, iBranchTaken,
           iJumpIp, iRAMWriteEnable, iRAMWriteAddress,
           iRAMWriteData,
    output oDecodeDone, oOperation, oSource0,
           oSource1, oDestination, oCodeDone
  );

  modport slave (
    output iExeBusy, iALUOutputReady, iBranchTaken,
           iJumpIp, iRAMWriteEnable, iRAMWriteAddress,
           iRAMWriteData,
    input  oDecodeDone, oOperation, oSource0,
           oSource1, oDestination, oCodeDone
  );
endinterface

// File: rtl/instruction_fetch_decode.sv
// Fetch/decode front end: ROM fetch, field split, operand
// read with RAW forwarding, one-cycle issue pulse, squash.
module instruction_fetch_decode #(
  parameter int OP_W   = 16,
  parameter int ADDR_W = 16,
  parameter int ROM_W  = 16,
  parameter int ROW_W  = 96,
  parameter int INST_W = 64,
  parameter logic [OP_W-1:0] RETURN_OP = 16'd1,
  parameter logic [OP_W-1:0] NOP_OP    = 16'd0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iEnable,
  input  logic [ROM_W-1:0]  iInitialIP,
  output logic [ROM_W-1:0]  oIP,
  input  logic [INST_W-1:0] iInstruction,
  output logic [ADDR_W-1:0] oRAMReadAddress0,
  output logic [ADDR_W-1:0] oRAMReadAddress1,
  input  logic [ROW_W-1:0]  iRAMData0,
  input  logic [ROW_W-1:0]  iRAMData1,
  instruction_fetch_decode_if.master exe
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_OPERAND = 3'd3;
  localparam logic [2:0] S_ISSUE   = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_HALT    = 3'd6;

  logic [2:0]        state;
  logic [ROM_W-1:0]  ip;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] dest_q, src0_q, src1_q;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_dest;
  logic [OP_W-1:0]   inflight_op;
  logic              haz0, haz1, fwd0, fwd1;
  logic [ROW_W-1:0]  fwd_data0, fwd_data1;
  logic [OP_W-1:0]   op_out;
  logic [ADDR_W-1:0] dest_out;
  logic [ROW_W-1:0]  src_out0, src_out1;
  logic              code_done;

  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_dest, in_src0, in_src1;
  logic              done, wr_en, squash, issue;
  logic              pend0, pend1, fwd_now0, fwd_now1;
  logic              front;

  assign in_src0 = iInstruction[ADDR_W-1:0];
  assign in_src1 = iInstruction[2*ADDR_W-1:ADDR_W];
  assign in_dest = iInstruction[3*ADDR_W-1:2*ADDR_W];
  assign in_op   = iInstruction[3*ADDR_W+OP_W-1:3*ADDR_W];

  assign done  = exe.iALUOutputReady;
  assign wr_en = exe.iRAMWriteEnable;
  assign front = (state == S_FETCH) || (state == S_DECODE)
              || (state == S_OPERAND) || (state == S_ISSUE);
  assign squash = done && exe.iBranchTaken && front;

  assign pend0 = inflight && (in_src0 == inflight_dest)
              && (inflight_op != NOP_OP);
  assign pend1 = inflight && (in_src1 == inflight_dest)
              && (inflight_op != NOP_OP);

  assign fwd_now0 = done && haz0 && wr_en
                 && (exe.iRAMWriteAddress == src0_q);
  assign fwd_now1 = done && haz1 && wr_en
                 && (exe.iRAMWriteAddress == src1_q);

  assign issue = (state == S_ISSUE) && !exe.iExeBusy
              && !haz0 && !haz1 && !squash;

  assign oIP = ip;
  assign oRAMReadAddress0 = (state == S_DECODE) ? in_src0 : src0_q;
  assign oRAMReadAddress1 = (state == S_DECODE) ? in_src1 : src1_q;

  assign exe.oDecodeDone  = issue;
  assign exe.oOperation   = op_out;
  assign exe.oDestination = dest_out;
  assign exe.oSource0     = src_out0;
  assign exe.oSource1     = src_out1;
  assign exe.oCodeDone    = code_done;

  // Sequencer, hazard tracking, operand capture and forwarding
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= S_IDLE;
      ip            <= '0;
      op_q          <= '0;
      dest_q        <= '0;
      src0_q        <= '0;
      src1_q        <= '0;
      inflight      <= 1'b0;
      inflight_dest <= '0;
      inflight_op   <= '0;
      haz0          <= 1'b0;
      haz1          <= 1'b0;
      fwd0          <= 1'b0;
      fwd1          <= 1'b0;
      fwd_data0     <= '0;
      fwd_data1     <= '0;
      op_out        <= '0;
      dest_out      <= '0;
      src_out0      <= '0;
      src_out1      <= '0;
      code_done     <= 1'b0;
    end else begin
      if (done) begin
        inflight <= 1'b0;
        haz0     <= 1'b0;
        haz1     <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (iEnable) begin
            ip    <= iInitialIP;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          op_q      <= in_op;
          dest_q    <= in_dest;
          src0_q    <= in_src0;
          src1_q    <= in_src1;
          haz0      <= pend0 && !done;
          haz1      <= pend1 && !done;
          fwd0      <= pend0 && done && wr_en
                    && (exe.iRAMWriteAddress == in_src0);
          fwd1      <= pend1 && done && wr_en
                    && (exe.iRAMWriteAddress == in_src1);
          fwd_data0 <= exe.iRAMWriteData;
          fwd_data1 <= exe.iRAMWriteData;
          state     <= S_OPERAND;
        end
        S_OPERAND: begin
          op_out   <= op_q;
          dest_out <= dest_q;
          src_out0 <= fwd_now0 ? exe.iRAMWriteData
                    : fwd0 ? fwd_data0 : iRAMData0;
          src_out1 <= fwd_now1 ? exe.iRAMWriteData
                    : fwd1 ? fwd_data1 : iRAMData1;
          state    <= S_ISSUE;
        end
        S_ISSUE: begin
          if (fwd_now0) src_out0 <= exe.iRAMWriteData;
          if (fwd_now1) src_out1 <= exe.iRAMWriteData;
          if (issue) begin
            inflight      <= 1'b1;
            inflight_dest <= dest_q;
            inflight_op   <= op_q;
            ip            <= ip + 1'b1;
            state <= (op_q == RETURN_OP) ? S_DRAIN : S_FETCH;
          end
        end
        S_DRAIN: begin
          if (done) begin
            code_done <= 1'b1;
            state     <= S_HALT;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
      if (squash) begin
        ip    <= exe.iJumpIp;
        state <= S_FETCH;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Bench for instruction_fetch_decode: ROM/RAM and execution
// unit models, architectural scoreboard, directed programs.
module tb_instruction_fetch_decode;
  localparam logic [15:0] OP_NOP = 16'd0;
  localparam logic [15:0] OP_RET = 16'd1;
  localparam logic [15:0] OP_ADD = 16'd2;
  localparam logic [15:0] OP_JMP = 16'd7;

  logic        Clock;
  logic        Reset;
  logic        iEnable;
  logic [15:0] iInitialIP;
  logic [15:0] oIP;
  logic [63:0] iInstruction;
  logic [15:0] oRAMReadAddress0, oRAMReadAddress1;
  logic [95:0] iRAMData0, iRAMData1;

  instruction_fetch_decode_if exe_if ();

  instruction_fetch_decode dut (
    .Clock(Clock),
    .Reset(Reset),
    .iEnable(iEnable),
    .iInitialIP(iInitialIP),
    .oIP(oIP),
    .iInstruction(iInstruction),
    .oRAMReadAddress0(oRAMReadAddress0),
    .oRAMReadAddress1(oRAMReadAddress1),
    .iRAMData0(iRAMData0),
    .iRAMData1(iRAMData1),
    .exe(exe_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [63:0] rom [0:255];
  logic [95:0] ram [0:255];

  int errors, checks, cyc, lat, br_cyc;
  logic        force_busy, exp_done, ex_active;
  logic [15:0] exp_pc, done_ip, ex_op, ex_dest, ex_tgt, rom_q;
  int          ex_cnt;
  logic [95:0] rd0, rd1;
  logic [15:0] ip_hist[$];
  int          iss_cyc[$];
  logic [95:0] iss_s0[$], iss_s1[$];
  logic [15:0] iss_dst[$];

  function automatic logic [95:0] row(input logic [7:0] a);
    return {16'h1111, 8'h00, a, 16'h2222, 8'h00, a,
            16'h3333, 8'h00, a};
  endfunction

  function automatic logic [95:0] wres(input logic [15:0] d);
    return {6{16'hAAAA}} ^ {80'd0, d};
  endfunction

  function automatic logic [63:0] mk(input logic [15:0] op,
    input logic [15:0] d, input logic [15:0] s1,
    input logic [15:0] s0);
    return {op, d, s1, s0};
  endfunction

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    logic        cmp, hz;
    logic [63:0] w;
    @(posedge Clock);
    #1;
    iInstruction = rom[rom_q[7:0]];
    iRAMData0 = rd0;
    iRAMData1 = rd1;
    cmp = ex_active && ex_cnt == 0;
    exe_if.iALUOutputReady  = cmp;
    exe_if.iRAMWriteEnable  = cmp && ex_op == OP_ADD;
    exe_if.iRAMWriteAddress = ex_dest;
    exe_if.iRAMWriteData    = wres(ex_dest);
    exe_if.iBranchTaken     = cmp && ex_op == OP_JMP;
    exe_if.iJumpIp          = ex_tgt;
    exe_if.iExeBusy = force_busy
                   || (ex_active && !cmp && ex_op != OP_NOP);
    #1;
    cyc++;
    ip_hist.push_back(oIP);
    chk("code_done", exe_if.oCodeDone, exp_done);
    if (exp_done) chk("halt_ip", oIP, done_ip);
    w = rom[exp_pc[7:0]];
    if (exe_if.oDecodeDone) begin
      hz = ex_active && !cmp && ex_op != OP_NOP
        && (w[15:0] == ex_dest || w[31:16] == ex_dest);
      chk("issue_op", exe_if.oOperation, w[63:48]);
      chk("issue_dest", exe_if.oDestination, w[47:32]);
      chk("issue_src0", exe_if.oSource0, ram[w[7:0]]);
      chk("issue_src1", exe_if.oSource1, ram[w[23:16]]);
      chk("issue_while_busy", exe_if.iExeBusy, 1'b0);
      chk("issue_in_hazard", hz, 1'b0);
      chk("issue_on_squash", exe_if.iBranchTaken, 1'b0);
      iss_cyc.push_back(cyc);
      iss_s0.push_back(exe_if.oSource0);
      iss_s1.push_back(exe_if.oSource1);
      iss_dst.push_back(exe_if.oDestination);
    end
    rom_q = oIP;
    rd0 = ram[oRAMReadAddress0[7:0]];
    rd1 = ram[oRAMReadAddress1[7:0]];
    if (cmp) begin
      ex_active = 1'b0;
      if (ex_op == OP_ADD) ram[ex_dest[7:0]] = wres(ex_dest);
      if (ex_op == OP_JMP) begin
        exp_pc = ex_tgt;
        br_cyc = cyc;
      end
      if (ex_op == OP_RET) begin
        exp_done = 1'b1;
        done_ip  = exp_pc;
      end
    end
    if (exe_if.oDecodeDone) begin
      exp_pc    = exp_pc + 16'd1;
      ex_active = 1'b1;
      ex_cnt    = lat - 1;
      ex_op     = w[63:48];
      ex_dest   = w[47:32];
      ex_tgt    = w[15:0];
    end else if (ex_active) begin
      ex_cnt--;
    end
  endtask

  task automatic do_reset();
    Reset      = 1'b0;
    iEnable    = 1'b0;
    ex_active  = 1'b0;
    exp_done   = 1'b0;
    force_busy = 1'b0;
    rd0 = '0;
    rd1 = '0;
    rom_q = '0;
    for (int i = 0; i < 256; i++) ram[i] = row(8'(i));
    iss_cyc.delete();
    iss_s0.delete();
    iss_s1.delete();
    iss_dst.delete();
    step();
    step();
    Reset = 1'b1;
  endtask

  task automatic begin_prog(input logic [15:0] ip);
    iInitialIP = ip;
    exp_pc     = ip;
    iEnable    = 1'b1;
    step();
    iEnable    = 1'b0;
  endtask

  task automatic run_until_done(input int max);
    int n;
    n = 0;
    while (!exp_done && n < max) begin
      step();
      n++;
    end
    step();
    chk("run_done", exe_if.oCodeDone, 1'b1);
  endtask

  initial begin
    int fcyc;
    errors = 0;
    checks = 0;
    cyc = 0;
    lat = 1;
    br_cyc = 0;
    exp_pc = '0;
    done_ip = '0;
    ex_op = '0;
    ex_dest = '0;
    ex_tgt = '0;
    ex_cnt = 0;
    iInitialIP = '0;
    for (int i = 0; i < 256; i++) rom[i] = '0;

    // independent ADD then RETURN completing one cycle later
    do_reset();
    rom[5] = mk(OP_ADD, 16'h10, 16'h3, 16'h4);
    rom[6] = mk(OP_RET, 16'h0, 16'h0, 16'h0);
    lat = 1;
    begin_prog(16'd5);
    fcyc = cyc;
    chk("s1_fetch_ip", oIP, 16'd5);
    run_until_done(200);
    chk("s1_issues", iss_cyc.size(), 2);
    if (iss_cyc.size() >= 1) begin
      chk("s1_latency", iss_cyc[0] - fcyc, 3);
      chk("s1_src0", iss_s0[0],
          96'h1111_0004_2222_0004_3333_0004);
      chk("s1_src1", iss_s1[0],
          96'h1111_0003_2222_0003_3333_0003);
      chk("s1_next_ip", ip_hist[iss_cyc[0]], 16'd6);
    end
    repeat (5) step();
    chk("s1_halt_ip", oIP, 16'd7);
    chk("s1_code_done", exe_if.oCodeDone, 1'b1);

    // RAW hazard with completion landing in each stage
    for (int l = 1; l <= 6; l++) begin
      do_reset();
      rom[8]  = mk(OP_ADD, 16'h20, 16'h1, 16'h2);
      rom[9]  = mk(OP_ADD, 16'h21, 16'h20,
                   (l % 2 == 1) ? 16'h20 : 16'h3);
      rom[10] = mk(OP_RET, 16'h0, 16'h0, 16'h0);
      lat = l;
      begin_prog(16'd8);
      run_until_done(200);
      chk("s2_issues", iss_cyc.size(), 3);
      if (iss_cyc.size() >= 2) begin
        chk("s2_fwd_src1", iss_s1[1],
            96'hAAAA_AAAA_AAAA_AAAA_AAAA_AA8A);
        if (l % 2 == 1)
          chk("s2_fwd_src0", iss_s0[1],
              96'hAAAA_AAAA_AAAA_AAAA_AAAA_AA8A);
        chk("s2_after_done", iss_cyc[1] > iss_cyc[0] + l, 1'b1);
      end
    end

    // NOP in flight never stalls a matching source
    do_reset();
    rom[8'h30] = mk(OP_NOP, 16'h20, 16'h1, 16'h2);
    rom[8'h31] = mk(OP_ADD, 16'h22, 16'h20, 16'h4);
    rom[8'h32] = mk(OP_RET, 16'h0, 16'h0, 16'h0);
    lat = 4;
    begin_prog(16'h30);
    run_until_done(200);
    chk("s3_issues", iss_cyc.size(), 3);
    if (iss_cyc.size() >= 2) begin
      chk("s3_gap", iss_cyc[1] - iss_cyc[0], 4);
      chk("s3_src1", iss_s1[1],
          96'h1111_0020_2222_0020_3333_0020);
    end

    // taken branch squashes the prefetched instruction
    do_reset();
    rom[8'h10] = mk(OP_JMP, 16'h0, 16'h0, 16'h40);
    rom[8'h11] = mk(OP_ADD, 16'h25, 16'h1, 16'h2);
    rom[8'h40] = mk(OP_ADD, 16'h30, 16'h5, 16'h6);
    rom[8'h41] = mk(OP_RET, 16'h0, 16'h0, 16'h0);
    lat = 6;
    begin_prog(16'h10);
    run_until_done(200);
    chk("s4_issues", iss_cyc.size(), 3);
    if (iss_cyc.size() >= 2)
      chk("s4_target_dest", iss_dst[1], 16'h30);
    chk("s4_jump_ip", ip_hist[br_cyc], 16'h40);

    // reset while stalled in issue, then restart with IP wrap
    do_reset();
    rom[8'h50] = mk(OP_ADD, 16'h27, 16'h1, 16'h2);
    lat = 1;
    force_busy = 1'b1;
    begin_prog(16'h50);
    repeat (4) step();
    Reset = 1'b0;
    #1;
    chk("s6_rst_done", exe_if.oDecodeDone, 1'b0);
    chk("s6_rst_ip", oIP, 16'h0);
    chk("s6_rst_op", exe_if.oOperation, 16'h0);
    chk("s6_rst_dest", exe_if.oDestination, 16'h0);
    chk("s6_rst_src0", exe_if.oSource0, 96'h0);
    chk("s6_rst_raddr", oRAMReadAddress0, 16'h0);
    chk("s6_rst_code", exe_if.oCodeDone, 1'b0);
    do_reset();
    rom[8'hFF] = mk(OP_ADD, 16'h26, 16'h7, 16'h8);
    rom[8'h00] = mk(OP_RET, 16'h0, 16'h0, 16'h0);
    begin_prog(16'hFFFF);
    chk("s6_fetch_ip", oIP, 16'hFFFF);
    run_until_done(200);
    chk("s6_issues", iss_cyc.size(), 2);
    if (iss_cyc.size() >= 1) begin
      chk("s6_wrap_ip", ip_hist[iss_cyc[0]], 16'h0);
      chk("s6_src0", iss_s0[0],
          96'h1111_0008_2222_0008_3333_0008);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
